rr_hazard_control: RTL

- Register-read (RR) stage control for the 8-bit, 4-register pipelined processor.
- Decodes the instruction in IR2 and keeps a per-register scoreboard of pending writebacks, counting issues into EX and retirements signalled by the writeback stage.
- Stalls the front end and injects a bubble into EX when a source register has a write in flight.
- Drives a STOP drain-and-halt sequence.
- Sits between IR2 and IR3; it is the read-side counterpart of writeback control.

---
 rtl/rr_hazard_control_pkg.sv | 42 ++++
 rtl/rr_decode.sv | 65 ++++++
 rtl/rr_hazard_control.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rr_hazard_control_pkg.sv
// Shared definitions for the register-read stage: opcodes, register
// encodings, scoreboard sizing and the drain/halt state enumeration.
package rr_hazard_control_pkg;

  localparam int unsigned NREGS = 4;
  localparam int unsigned CNTW  = 2;

  localparam logic [1:0] REG_R0 = 2'd0;
  localparam logic [1:0] REG_R1 = 2'd1;
  localparam logic [1:0] REG_R2 = 2'd2;
  localparam logic [1:0] REG_R3 = 2'd3;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  // SHIFT is x011 and ORI is x111: match the low three bits only
  localparam logic [3:0] OP_SHIFT_MASK = 4'b0111;
  localparam logic [3:0] OP_SHIFT_PAT  = 4'b0011;
  localparam logic [3:0] OP_ORI_MASK   = 4'b0111;
  localparam logic [3:0] OP_ORI_PAT    = 4'b0111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rr_state_e;

  function automatic logic [NREGS-1:0] reg_onehot(input logic [1:0] r);
    logic [NREGS-1:0] oh;
    oh    = '0;
    oh[r] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_decode.sv
// Combinational decode of the RR-stage instruction: which registers are
// read, whether and where a result is written, STOP detect, RF addresses.
module rr_decode
  import rr_hazard_control_pkg::*;
(
  input  logic [7:0]       ir_i,
  output logic [NREGS-1:0] rmask_o,
  output logic             wr_o,
  output logic [1:0]       dest_o,
  output logic             is_stop_o,
  output logic [1:0]       rega_o,
  output logic [1:0]       regb_o
);

  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] op;

  assign rx = ir_i[7:6];
  assign ry = ir_i[5:4];
  assign op = ir_i[3:0];

  // Opcode decode into read set, write flag/destination and read addresses
  always_comb begin
    rmask_o   = '0;
    wr_o      = 1'b0;
    dest_o    = rx;
    is_stop_o = 1'b0;
    rega_o    = rx;
    regb_o    = ry;
    if ((op & OP_SHIFT_MASK) == OP_SHIFT_PAT) begin
      rmask_o = reg_onehot(rx);
      wr_o    = 1'b1;
    end else if ((op & OP_ORI_MASK) == OP_ORI_PAT) begin
      rmask_o = reg_onehot(REG_R1);
      wr_o    = 1'b1;
      dest_o  = REG_R1;
      rega_o  = REG_R1;
    end else begin
      case (op)
        OP_LOAD: begin
          rmask_o = reg_onehot(ry);
          wr_o    = 1'b1;
        end
        OP_STORE: begin
          rmask_o = reg_onehot(rx) | reg_onehot(ry);
        end
        OP_ADD, OP_SUB, OP_NAND: begin
          rmask_o = reg_onehot(rx) | reg_onehot(ry);
          wr_o    = 1'b1;
        end
        OP_STOP: begin
          is_stop_o = 1'b1;
        end
        OP_BZ, OP_BNZ, OP_BPZ: begin
          rmask_o = '0;
        end
        default: begin
          rmask_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rr_hazard_control.sv
// Register-read stage control: pending-write scoreboard, RAW stall and
// bubble injection, and the STOP drain-and-halt sequence.
module rr_hazard_control #(
  parameter int unsigned NREGS = rr_hazard_control_pkg::NREGS,
  parameter int unsigned CNTW  = rr_hazard_control_pkg::CNTW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       IR2,
  input  logic             IR2Valid,
  input  logic             Flush,
  input  logic             WBValid,
  input  logic [1:0]       WBReg,
  output logic [1:0]       RegA,
  output logic [1:0]       RegB,
  output logic             Stall,
  output logic             IR3Load,
  output logic             IR3Bubble,
  output logic             Halted,
  output logic             ErrSticky,
  output logic [NREGS-1:0] Pending
);

  import rr_hazard_control_pkg::*;

  rr_state_e        state_q, state_d;
  logic [NREGS-1:0] rd_mask;
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] inc_vec;
  logic [NREGS-1:0] dec_vec;
  logic [NREGS-1:0] uf_vec;
  logic             dec_wr;
  logic             dec_stop;
  logic [1:0]       dec_dest;
  logic             hazard;
  logic             issue;
  logic             all_idle;
  logic             err_q, err_d;

  rr_decode u_decode (
    .ir_i      (IR2),
    .rmask_o   (rd_mask),
    .wr_o      (dec_wr),
    .dest_o    (dec_dest),
    .is_stop_o (dec_stop),
    .rega_o    (RegA),
    .regb_o    (RegB)
  );

  // No same-cycle WB bypass: a source with any pending write stalls
  assign hazard   = IR2Valid & (|(rd_mask & pend));
  assign all_idle = ~|pend;
  assign inc_vec  = (issue & dec_wr) ? reg_onehot(dec_dest) : '0;
  assign dec_vec  = WBValid ? reg_onehot(WBReg) : '0;

  for (genvar g = 0; g < NREGS; g++) begin : g_sb
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            uf;

    // Per-register pending count; simultaneous issue and retire cancel out
    always_comb begin
      cnt_d = cnt_q;
      uf    = 1'b0;
      if (inc_vec[g] && !dec_vec[g]) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (dec_vec[g] && !inc_vec[g]) begin
        if (cnt_q == '0) begin
          uf = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end

    // Count register
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign pend[g]   = |cnt_q;
    assign uf_vec[g] = uf;
  end

  // Next state plus issue/stall/bubble outputs for the current state
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    Stall     = 1'b0;
    IR3Load   = 1'b1;
    IR3Bubble = 1'b1;
    Halted    = 1'b0;
    unique case (state_q)
      RUN: begin
        issue     = IR2Valid & ~hazard & ~Flush;
        Stall     = hazard & ~Flush;
        IR3Bubble = ~issue;
        if (issue && dec_stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        Stall = 1'b1;
        if (all_idle && !WBValid) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        Stall   = 1'b1;
        IR3Load = 1'b0;
        Halted  = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign err_d = err_q | (|uf_vec);

  // State and sticky underflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign ErrSticky = err_q;
  assign Pending   = pend;

endmodule
